id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Parametrised ID→EX pipeline register for the 5-stage core.
- Carries the decoded ALU op/sel, operands, destination, write-enable, link address, instruction word and delay-slot flags.
- Adds what the previous single-field register lacked: stall hold, bubble insertion, flush, a valid bit, a delay-slot feedback loop back to decode, and a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, operand / link-address / instruction width
- ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width
- ALUSEL_W, 3, ALU result-select width
- STALL_W, 6, width of the pipeline stall vector from ctrl
- ID_IDX, 2, stall-vector bit index of the ID stage
- EX_IDX, 3, stall-vector bit index of the EX stage
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  per-stage stall request from ctrl
- flush  in  1  exception/redirect flush
- id_valid  in  1  decode stage holds a real instruction
- id_aluop  in  ALUOP_W  decoded ALU op
- id_alusel  in  ALUSEL_W  decoded result select
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wd  in  ADDR_W  destination register
- id_wreg  in  1  register write enable
- id_link_addr  in  DATA_W  return address for link instructions
- id_inst  in  DATA_W  raw instruction word
- id_in_delayslot  in  1  current ID instruction is in a delay slot
- id_next_in_delayslot  in  1  current ID instruction is a branch/jump
- ex_valid  out  1  EX holds a real instruction
- ex_aluop  out  ALUOP_W
- ex_alusel  out  ALUSEL_W
- ex_reg1  out  DATA_W
- ex_reg2  out  DATA_W
- ex_wd  out  ADDR_W
- ex_wreg  out  1
- ex_link_addr  out  DATA_W
- ex_inst  out  DATA_W
- ex_in_delayslot  out  1
- id_is_in_delayslot  out  1  registered feedback to decode: next ID instruction is a delay slot
- stall_cycles  out  CNT_W  count of EX-hold cycles since reset

Behaviour:
- Reset (async, rst=1), all outputs zero:
  - ex_aluop = NOP op (0); ex_alusel = NOP sel (0).
  - ex_reg1/reg2/link_addr/inst = 0; ex_wd = 0.
  - ex_wreg, ex_valid, ex_in_delayslot, id_is_in_delayslot = 0.
  - stall_cycles = 0.
  - Reset mid-stall or mid-flush discards everything immediately (no clock needed).
- Per rising edge, priority order:
  - (1) flush=1: load bubble — ex_valid=0, ex_wreg=0, NOP op/sel, data fields 0, ex_in_delayslot=0, id_is_in_delayslot=0. Flush overrides any stall.
  - (2) stall[ID_IDX]=1 and stall[EX_IDX]=0: insert bubble as in (1), except id_is_in_delayslot holds its value.
  - (3) stall[EX_IDX]=1: hold every ex_* output and id_is_in_delayslot unchanged.
  - (4) otherwise advance: all ex_* fields ← corresponding id_* inputs.
    - ex_valid ← id_valid.
    - ex_wreg ← id_wreg & id_valid (an invalid ID slot never writes).
    - id_is_in_delayslot ← id_next_in_delayslot & id_valid.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs when advancing.
- stall_cycles:
  - Increments by 1 on every edge where rule (3) applies and ex_valid=1.
  - Saturates at all-ones; never wraps.
  - Unaffected by flush; cleared only by rst.
- Stall bits other than ID_IDX and EX_IDX are ignored.
- Bubbles are indistinguishable from the reset state on the ex_* outputs.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/include holds the constants: NOP op/sel encodings, zero word, NOP register address, write enable/disable values, stall-vector indices.
- One natural sub-module: pipe_sat_counter (CNT_W, enable, async rst, saturating), reusable by other stage registers for performance counters.
- Field registers stay inline.

Test Plan:
- Reset: assert rst between edges with all inputs nonzero → every output 0 immediately; stall_cycles=0.
- Advance: id_valid=1, aluop=0x21, reg1=0x1234, reg2=0x5678, wd=5, wreg=1, stall=0 → next edge ex_* match; ex_valid=1.
- EX hold: stall=6'b001111 for 3 edges while ID inputs change → ex_* frozen at prior values; stall_cycles increments 0→3.
- Bubble: stall=6'b000111 → next edge ex_valid=0, ex_wreg=0, ex_aluop=0, id_is_in_delayslot unchanged.
- Delay slot: advance a branch with id_next_in_delayslot=1 → id_is_in_delayslot=1. Then advance the slot instruction with id_in_delayslot=1 → ex_in_delayslot=1.
- Flush vs stall: flush=1 with stall=6'b001111 → bubble loaded; id_is_in_delayslot=0. Then preset stall_cycles to all-ones via forced long stall → remains 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg
// Shared constants for the ID->EX stage register: NOP encodings, zero
// values, write-enable levels, default stall-vector indices, and the
// per-edge action selector used by the pipeline register.
package id_ex_pipe_pkg;

    localparam logic [7:0]  NOP_ALUOP     = 8'h00;
    localparam logic [2:0]  NOP_ALUSEL    = 3'b000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    localparam int STALL_ID_IDX = 2;
    localparam int STALL_EX_IDX = 3;

    typedef enum logic [1:0] {
        PIPE_ADVANCE = 2'd0,
        PIPE_HOLD    = 2'd1,
        PIPE_BUBBLE  = 2'd2,
        PIPE_FLUSH   = 2'd3
    } pipe_action_e;

    // Flush beats everything; an ID-only stall becomes a bubble; an EX
    // stall freezes the register.
    function automatic pipe_action_e pipe_action(input logic flush,
                                                 input logic id_stall,
                                                 input logic ex_stall);
        if (flush)
            return PIPE_FLUSH;
        else if (id_stall && !ex_stall)
            return PIPE_BUBBLE;
        else if (ex_stall)
            return PIPE_HOLD;
        else
            return PIPE_ADVANCE;
    endfunction

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// pipe_sat_counter
// Saturating up-counter for stage performance statistics.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, clears the count
//   en_i    - count this cycle
//   count_o - current count, sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
// ID->EX pipeline register with stall hold, bubble insertion, flush,
// valid tracking, delay-slot feedback to decode and a saturating count
// of cycles in which a valid EX instruction was held.
// Ports:
//   clk, rst                 - clock / async active-high reset
//   stall, flush             - pipeline control from ctrl
//   id_*                     - decoded instruction fields from ID
//   ex_*                     - registered fields presented to EX
//   id_is_in_delayslot       - registered: next ID instruction is a slot
//   stall_cycles             - EX-hold cycle count since reset
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int STALL_W  = 6,
    parameter int ID_IDX   = STALL_ID_IDX,
    parameter int EX_IDX   = STALL_EX_IDX,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_wd,
    input  logic                id_wreg,
    input  logic [DATA_W-1:0]   id_link_addr,
    input  logic [DATA_W-1:0]   id_inst,
    input  logic                id_in_delayslot,
    input  logic                id_next_in_delayslot,
    output logic                ex_valid,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [ADDR_W-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [DATA_W-1:0]   ex_link_addr,
    output logic [DATA_W-1:0]   ex_inst,
    output logic                ex_in_delayslot,
    output logic                id_is_in_delayslot,
    output logic [CNT_W-1:0]    stall_cycles
);

    pipe_action_e action;

    logic                valid_q,    valid_d;
    logic [ALUOP_W-1:0]  aluop_q,    aluop_d;
    logic [ALUSEL_W-1:0] alusel_q,   alusel_d;
    logic [DATA_W-1:0]   reg1_q,     reg1_d;
    logic [DATA_W-1:0]   reg2_q,     reg2_d;
    logic [ADDR_W-1:0]   wd_q,       wd_d;
    logic                wreg_q,     wreg_d;
    logic [DATA_W-1:0]   link_q,     link_d;
    logic [DATA_W-1:0]   inst_q,     inst_d;
    logic                in_ds_q,    in_ds_d;
    logic                next_ds_q,  next_ds_d;

    // Only the ID and EX bits of the stall vector matter here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    assign action = pipe_action(flush, stall[ID_IDX], stall[EX_IDX]);

    always_comb begin
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        alusel_d  = alusel_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        link_d    = link_q;
        inst_d    = inst_q;
        in_ds_d   = in_ds_q;
        next_ds_d = next_ds_q;

        unique case (action)
            PIPE_FLUSH, PIPE_BUBBLE: begin
                valid_d  = 1'b0;
                aluop_d  = ALUOP_W'(NOP_ALUOP);
                alusel_d = ALUSEL_W'(NOP_ALUSEL);
                reg1_d   = DATA_W'(ZERO_WORD);
                reg2_d   = DATA_W'(ZERO_WORD);
                wd_d     = ADDR_W'(NOP_REG_ADDR);
                wreg_d   = WRITE_DISABLE;
                link_d   = DATA_W'(ZERO_WORD);
                inst_d   = DATA_W'(ZERO_WORD);
                in_ds_d  = 1'b0;
                // A bubble keeps the pending delay-slot marker so the slot
                // instruction still gets tagged once decode is released.
                if (action == PIPE_FLUSH)
                    next_ds_d = 1'b0;
            end
            PIPE_ADVANCE: begin
                valid_d   = id_valid;
                aluop_d   = id_aluop;
                alusel_d  = id_alusel;
                reg1_d    = id_reg1;
                reg2_d    = id_reg2;
                wd_d      = id_wd;
                wreg_d    = id_valid ? id_wreg : WRITE_DISABLE;
                link_d    = id_link_addr;
                inst_d    = id_inst;
                in_ds_d   = id_in_delayslot;
                next_ds_d = id_next_in_delayslot & id_valid;
            end
            default: ;  // PIPE_HOLD keeps every field
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            aluop_q   <= ALUOP_W'(NOP_ALUOP);
            alusel_q  <= ALUSEL_W'(NOP_ALUSEL);
            reg1_q    <= DATA_W'(ZERO_WORD);
            reg2_q    <= DATA_W'(ZERO_WORD);
            wd_q      <= ADDR_W'(NOP_REG_ADDR);
            wreg_q    <= WRITE_DISABLE;
            link_q    <= DATA_W'(ZERO_WORD);
            inst_q    <= DATA_W'(ZERO_WORD);
            in_ds_q   <= 1'b0;
            next_ds_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            alusel_q  <= alusel_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            link_q    <= link_d;
            inst_q    <= inst_d;
            in_ds_q   <= in_ds_d;
            next_ds_q <= next_ds_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    ((action == PIPE_HOLD) && valid_q),
        .count_o (stall_cycles)
    );

    assign ex_valid           = valid_q;
    assign ex_aluop           = aluop_q;
    assign ex_alusel          = alusel_q;
    assign ex_reg1            = reg1_q;
    assign ex_reg2            = reg2_q;
    assign ex_wd              = wd_q;
    assign ex_wreg            = wreg_q;
    assign ex_link_addr       = link_q;
    assign ex_inst            = inst_q;
    assign ex_in_delayslot    = in_ds_q;
    assign id_is_in_delayslot = next_ds_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OW  = 8;
    localparam int SW  = 3;
    localparam int STW = 6;
    localparam int CW  = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [STW-1:0] stall = '0;
    logic           flush = 1'b0;
    logic           id_valid = 1'b0;
    logic [OW-1:0]  id_aluop = '0;
    logic [SW-1:0]  id_alusel = '0;
    logic [DW-1:0]  id_reg1 = '0, id_reg2 = '0, id_link_addr = '0, id_inst = '0;
    logic [AW-1:0]  id_wd = '0;
    logic           id_wreg = 1'b0, id_in_delayslot = 1'b0, id_next_in_delayslot = 1'b0;

    logic           ex_valid, ex_wreg, ex_in_delayslot, id_is_in_delayslot;
    logic [OW-1:0]  ex_aluop;
    logic [SW-1:0]  ex_alusel;
    logic [DW-1:0]  ex_reg1, ex_reg2, ex_link_addr, ex_inst;
    logic [AW-1:0]  ex_wd;
    logic [CW-1:0]  stall_cycles;

    id_ex_pipe #(
        .DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .ALUSEL_W(SW),
        .STALL_W(STW), .ID_IDX(2), .EX_IDX(3), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .id_link_addr(id_link_addr), .id_inst(id_inst),
        .id_in_delayslot(id_in_delayslot), .id_next_in_delayslot(id_next_in_delayslot),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_link_addr(ex_link_addr), .ex_inst(ex_inst),
        .ex_in_delayslot(ex_in_delayslot), .id_is_in_delayslot(id_is_in_delayslot),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [OW-1:0] aluop;
        logic [SW-1:0] alusel;
        logic [DW-1:0] reg1;
        logic [DW-1:0] reg2;
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] link;
        logic [DW-1:0] inst;
        logic          in_ds;
        logic          next_ds;
        logic [CW-1:0] cnt;
    } st_t;

    st_t   m = '0;
    st_t   exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    event  async_ev;

    // Monitor: compares the DUT against the oldest queued expectation
    // after every rising edge, or right after an asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                st_t   e, a;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
                     ex_link_addr, ex_inst, ex_in_delayslot, id_is_in_delayslot, stall_cycles};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %h required %h (cnt got %0d required %0d)",
                             t, $time, a, e, a.cnt, e.cnt);
                end
            end
        end
    end

    task automatic rand_id();
        id_valid             = 1'($urandom_range(0, 3) != 0);
        id_aluop             = OW'($urandom);
        id_alusel            = SW'($urandom);
        id_reg1              = $urandom;
        id_reg2              = $urandom;
        id_wd                = AW'($urandom);
        id_wreg              = 1'($urandom);
        id_link_addr         = $urandom;
        id_inst              = $urandom;
        id_in_delayslot      = 1'($urandom);
        id_next_in_delayslot = 1'($urandom);
    endtask

    // Reference model: predict the register contents after the next edge,
    // queue it, then let the edge happen. Called on a falling edge.
    task automatic cycle(input string tag);
        st_t n;
        n = m;
        if (flush) begin
            n = '0;
            n.cnt = m.cnt;
        end else if (stall[2] && !stall[3]) begin
            n = '0;
            n.next_ds = m.next_ds;
            n.cnt = m.cnt;
        end else if (stall[3]) begin
            if (m.valid && m.cnt != {CW{1'b1}})
                n.cnt = m.cnt + 1'b1;
        end else begin
            n.valid   = id_valid;
            n.aluop   = id_aluop;
            n.alusel  = id_alusel;
            n.reg1    = id_reg1;
            n.reg2    = id_reg2;
            n.wd      = id_wd;
            n.wreg    = id_wreg && id_valid;
            n.link    = id_link_addr;
            n.inst    = id_inst;
            n.in_ds   = id_in_delayslot;
            n.next_ds = id_next_in_delayslot && id_valid;
        end
        m = n;
        exp_q.push_back(n);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges with busy inputs; outputs must clear
    // at once and stay clear across an edge while rst is held.
    task automatic do_reset(input string tag);
        rand_id();
        id_valid = 1'b1;
        id_wreg  = 1'b1;
        id_next_in_delayslot = 1'b1;
        stall = 6'b001111;
        flush = 1'b1;
        #1;
        rst = 1'b1;
        m = '0;
        exp_q.push_back(m);
        tag_q.push_back(tag);
        ->async_ev;
        #2;
        exp_q.push_back(m);
        tag_q.push_back({tag, "_held"});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        stall = '0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");

        // Advance a known instruction (a branch, so the delay-slot flag rises)
        id_valid = 1; id_aluop = 8'h21; id_alusel = 3'd1; id_reg1 = 32'h1234;
        id_reg2 = 32'h5678; id_wd = 5'd5; id_wreg = 1; id_link_addr = 32'h100;
        id_inst = 32'hDEAD_BEEF; id_in_delayslot = 0; id_next_in_delayslot = 1;
        stall = '0; flush = 0;
        cycle("advance");

        // EX hold while ID changes
        stall = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            cycle("ex_hold");
        end

        // ID-only stall: bubble, delay-slot feedback kept
        rand_id();
        stall = 6'b000111;
        cycle("bubble");

        // Delay slot: branch then its slot
        stall = '0;
        rand_id(); id_valid = 1; id_in_delayslot = 0; id_next_in_delayslot = 1;
        cycle("ds_branch");
        rand_id(); id_valid = 1; id_in_delayslot = 1; id_next_in_delayslot = 0;
        cycle("ds_slot");

        // Invalid ID slot never writes nor marks a delay slot
        rand_id(); id_valid = 0; id_wreg = 1; id_next_in_delayslot = 1;
        cycle("invalid_slot");

        // Flush beats an EX stall
        rand_id(); id_valid = 1; id_next_in_delayslot = 1;
        cycle("pre_flush");
        stall = 6'b001111; flush = 1; rand_id();
        cycle("flush_vs_stall");
        flush = 0;

        // Stall bits outside ID/EX are ignored
        stall = 6'b110011; rand_id();
        cycle("other_bits");

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 1500; i++) begin
            int r;
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_reset");
            end else begin
                rand_id();
                r = $urandom_range(0, 9);
                if (r < 5)       stall = STW'($urandom) & 6'b110011;
                else if (r < 8)  stall = STW'($urandom) | 6'b001000;
                else if (r == 8) stall = (STW'($urandom) & 6'b110111) | 6'b000100;
                else             stall = STW'($urandom);
                flush = ($urandom_range(0, 15) == 0);
                cycle("random");
            end
        end

        // Saturate the stall counter with a long EX hold on a valid instruction
        flush = 0; stall = '0; rand_id(); id_valid = 1;
        cycle("sat_load");
        stall = 6'b001000;
        for (int i = 0; i < (1 << CW) + 8; i++) begin
            rand_id();
            cycle("sat_hold");
        end
        flush = 1; stall = 6'b001111;
        cycle("sat_flush");
        flush = 0; stall = '0; rand_id();
        cycle("sat_after");
        if (m.cnt != {CW{1'b1}}) begin
            n_tests++;
            n_fail++;
            $display("FAIL sat_model: model count %h did not reach all-ones", m.cnt);
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
